// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the weight column paths.
package nn_pkg;
  localparam int NUM_WEIGHTS   = 784;
  localparam int WEIGHT_ADDR_W = 10;
  localparam int WEIGHT_IN_W   = 16;
  localparam int WEIGHT_OUT_W  = 12;
  localparam int WEIGHT_SUM_W  = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wr_state_e;
endpackage

// File: rtl/weight_writer_if.sv
// Weight stream (valid/ready) plus RAM write port of the weight writer.
interface weight_writer_if
  import nn_pkg::*;
#(
  parameter int IN_W   = WEIGHT_IN_W,
  parameter int ADDR_W = WEIGHT_ADDR_W,
  parameter int OUT_W  = WEIGHT_OUT_W
) ();
  logic              w_valid;
  logic              w_ready;
  logic [IN_W-1:0]   w_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [OUT_W-1:0]  mem_din;

  // writer side: consumes the stream, drives the RAM port
  modport slave  (input  w_valid, w_data,
                  output w_ready, mem_we, mem_addr, mem_din);
  // producer / observer side
  modport master (output w_valid, w_data,
                  input  w_ready, mem_we, mem_addr, mem_din);
endinterface

// File: rtl/weight_pack.sv
// Packs a 16-bit signed internal weight into the 12-bit stored word.
// Inverse of the read-side {w[11],4'b0,w[10:0]} unpack for in-range values;
// out-of-range magnitudes clamp to full scale with the sign preserved.
module weight_pack (
  input  logic [15:0] in,
  output logic [11:0] out,
  output logic        sat
);
  // any bit set in the unused magnitude field means the value cannot be stored
  always_comb begin
    sat = |in[14:11];
    out = {in[15], sat ? 11'h7FF : in[10:0]};
  end
endmodule

// File: rtl/weight_writer.sv
// Streams a trained weight column into the weight RAM, one write per
// accepted weight, with saturation count and checksum of stored words.
module weight_writer
  import nn_pkg::*;
#(
  parameter int NUM_WEIGHTS = nn_pkg::NUM_WEIGHTS,
  parameter int ADDR_W      = WEIGHT_ADDR_W,
  parameter int IN_W        = WEIGHT_IN_W,
  parameter int OUT_W       = WEIGHT_OUT_W,
  parameter int SUM_W       = WEIGHT_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  weight_writer_if.slave    wif,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sat_count,
  output logic [SUM_W-1:0]  checksum
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WEIGHTS - 1);

  wr_state_e         state;
  logic [ADDR_W-1:0] counter;
  logic [OUT_W-1:0]  pk;
  logic              pk_sat;
  logic              xfer;

  weight_pack u_pack (
    .in  (wif.w_data),
    .out (pk),
    .sat (pk_sat)
  );

  assign wif.w_ready = (state == RUN);
  assign xfer        = wif.w_valid && wif.w_ready;

  // pass FSM, address counter, registered RAM port and accumulators
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      counter      <= '0;
      wif.mem_we   <= 1'b0;
      wif.mem_addr <= '0;
      wif.mem_din  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat_count    <= '0;
      checksum     <= '0;
    end else begin
      wif.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            counter   <= '0;
            sat_count <= '0;
            checksum  <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            wif.mem_we   <= 1'b1;
            wif.mem_addr <= counter;
            wif.mem_din  <= pk;
            checksum     <= checksum + SUM_W'(pk);
            // clamp count sticks at full scale rather than wrapping
            if (pk_sat && (sat_count != '1))
              sat_count <= sat_count + ADDR_W'(1);
            if (counter == LAST) begin
              counter <= '0;
              state   <= FLUSH;
            end else begin
              counter <= counter + ADDR_W'(1);
            end
          end
        end
        FLUSH: begin
          // last write is on the port this cycle
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_weight_writer.sv
// Directed bench for weight_writer with a per-cycle behavioural model.
module tb_weight_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [9:0]  sat_count;
  logic [23:0] checksum;

  weight_writer_if wif ();

  weight_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wif       (wif.slave),
    .busy      (busy),
    .done      (done),
    .sat_count (sat_count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // stored-word value from the numeric rules: sign to bit 11, magnitude
  // clamped to 2047 whenever any of bits 14:11 is set
  function automatic int pack_ref(input int w);
    int sgn, hi;
    sgn = (w >> 15) & 1;
    hi  = (w >> 11) & 15;
    return sgn * 2048 + ((hi != 0) ? 2047 : (w & 2047));
  endfunction

  function automatic bit sat_ref(input int w);
    return ((w >> 11) & 15) != 0;
  endfunction

  // ---------------- behavioural model ----------------
  bit m_armed = 0;
  int m_phase = 0;   // 0 waiting, 1 accepting, 2 last write out, 3 finished
  int m_idx = 0, m_sat = 0, m_sum = 0;
  bit m_we = 0, m_done = 0, m_busy = 0;
  int m_addr = 0, m_din = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_armed = 1; m_phase = 0; m_idx = 0; m_sat = 0; m_sum = 0;
      m_we = 0; m_done = 0; m_busy = 0; m_addr = 0; m_din = 0;
    end else begin
      m_we = 0; m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_busy = 1; m_idx = 0; m_sat = 0; m_sum = 0;
        end
      end else if (m_phase == 1) begin
        if (wif.w_valid) begin
          m_we   = 1;
          m_addr = m_idx;
          m_din  = pack_ref(int'(wif.w_data));
          m_sum  = (m_sum + m_din) % (1 << 24);
          if (sat_ref(int'(wif.w_data)) && m_sat < 1023) m_sat++;
          m_idx++;
          if (m_idx == 784) begin m_idx = 0; m_phase = 2; end
        end
      end else if (m_phase == 2) begin
        m_done = 1; m_busy = 0; m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- capture + per-cycle compare ----------------
  int cap_addr [0:1023];
  int cap_din  [0:1023];
  int wr_cnt = 0, done_cnt = 0, first_we_cyc = -1, xfer_cyc = -2;

  always @(negedge clk) begin
    if (m_armed) begin
      chk("w_ready", {31'b0, wif.w_ready}, {31'b0, m_phase == 1});
      chk("mem_we", {31'b0, wif.mem_we}, {31'b0, m_we});
      if (m_we) begin
        chk("mem_addr", {22'b0, wif.mem_addr}, m_addr);
        chk("mem_din", {20'b0, wif.mem_din}, m_din);
      end
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("sat_count", {22'b0, sat_count}, m_sat);
      chk("checksum", {8'b0, checksum}, m_sum);
      if (wif.mem_we === 1'b1 && wr_cnt < 1024) begin
        if (wr_cnt == 0) first_we_cyc = cyc;
        cap_addr[wr_cnt] = int'(wif.mem_addr);
        cap_din[wr_cnt]  = int'(wif.mem_din);
        wr_cnt++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  logic [15:0] pk_vec [0:3];

  function automatic logic [15:0] data_for(input int mode, input int i);
    if (mode == 2) return (i < 4) ? pk_vec[i] : 16'h0000;
    return 16'(i % 2048);
  endfunction

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; first_we_cyc = -1; xfer_cyc = -2;
  endtask

  task automatic post_checks(input int mode);
    int bad = 0;
    chk("n_writes", wr_cnt, 784);
    chk("done_pulses", done_cnt, 1);
    chk("first_we_latency", first_we_cyc, xfer_cyc);
    for (int k = 0; k < wr_cnt; k++) if (cap_addr[k] != k) bad++;
    chk("addr_seq_bad", bad, 0);
    if (mode == 0) begin
      chk("pass0_checksum", {8'b0, checksum}, 306936);
      chk("pass0_sat", {22'b0, sat_count}, 0);
    end
    if (mode == 2) begin
      chk("pack0", cap_din[0], 32'h923);
      chk("pack1", cap_din[1], 32'h7FF);
      chk("pack2", cap_din[2], 32'h7FF);
      chk("pack3", cap_din[3], 32'hFFF);
      chk("pack_sat", {22'b0, sat_count}, 3);
      chk("pack_checksum", {8'b0, checksum}, 10528);
    end
  endtask

  // mode 0 plain, 1 gaps, 2 packing, 3 spurious control, 4 reset at 400
  task automatic run_pass(input int mode, input bit start_given, input bit b2b);
    int i = 0, p = 0;
    bit v, found;
    if (!start_given) begin
      clear_log();
      if (mode == 3) begin
        wif.w_valid = 1'b1; wif.w_data = 16'h0555;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_w_ready", {31'b0, wif.w_ready}, 0);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (i < 784) begin
      v = (mode == 1) ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
      wif.w_valid = v;
      wif.w_data  = v ? data_for(mode, i) : 16'h7ABC;
      start = (mode == 3 && v && i == 100);
      @(posedge clk); #1;
      start = 1'b0;
      if (v) begin
        if (i == 0) xfer_cyc = cyc;
        if (mode == 4 && i == 400) begin
          wif.w_valid = 1'b0;
          chk("abort_last_addr", {22'b0, wif.mem_addr}, 400);
          rst = 1'b0;
          @(posedge clk); #1;
          chk("abort_we", {31'b0, wif.mem_we}, 0);
          chk("abort_busy", {31'b0, busy}, 0);
          chk("abort_sat", {22'b0, sat_count}, 0);
          chk("abort_sum", {8'b0, checksum}, 0);
          rst = 1'b1;
          @(posedge clk); #1;
          return;
        end
        i++;
      end
      p++;
    end
    wif.w_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1;
    end
    chk("done_seen", {31'b0, found}, 1);
    if (b2b) start = 1'b1;
    @(posedge clk); #1;
    post_checks(mode);
    if (b2b) begin
      chk("start_in_done_ignored", {31'b0, busy}, 0);
      clear_log();
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", {31'b0, busy}, 1);
      chk("b2b_sum_clr", {8'b0, checksum}, 0);
      chk("b2b_sat_clr", {22'b0, sat_count}, 0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    pk_vec[0] = 16'h8123; pk_vec[1] = 16'h0FFF;
    pk_vec[2] = 16'h1001; pk_vec[3] = 16'hF800;
    wif.w_valid = 1'b0; wif.w_data = 16'h0000;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_w_ready", {31'b0, wif.w_ready}, 0);
    chk("rst_mem_we", {31'b0, wif.mem_we}, 0);
    chk("rst_mem_addr", {22'b0, wif.mem_addr}, 0);
    chk("rst_mem_din", {20'b0, wif.mem_din}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sat", {22'b0, sat_count}, 0);
    chk("rst_sum", {8'b0, checksum}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_pass(0, 1'b0, 1'b0);
    run_pass(1, 1'b0, 1'b0);
    run_pass(2, 1'b0, 1'b1);
    run_pass(0, 1'b1, 1'b0);
    run_pass(3, 1'b0, 1'b0);
    clear_log();
    run_pass(4, 1'b0, 1'b0);
    run_pass(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/weight_writer.md
Name: weight_writer

Overview:
- Writes the trained 784-entry weight column back into the 12-bit weight block RAM.
- It is the write-side counterpart of the weight-column read path. It packs each internal 16-bit signed weight into the 12-bit stored word and issues sequential RAM writes.
- It sits between the back-propagation stage, which streams weights through a valid/ready handshake, and the weight RAM write port.

Parameters:
- NUM_WEIGHTS, 784, number of weights per column; the write address wraps to 0 after NUM_WEIGHTS-1.
- ADDR_W, 10, RAM address width.
- IN_W, 16, internal weight width.
- OUT_W, 12, stored word width.
- SUM_W, 24, checksum width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets).
- start  in  1  single-cycle pulse that begins a column write.
- w_valid  in  1  input weight valid.
- w_ready  out  1  block accepts a weight this cycle.
- w_data  in  IN_W  signed weight; bit 15 is sign, bits 10:0 are magnitude field, bits 14:11 must be zero.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM write address.
- mem_din  out  OUT_W  RAM write data.
- busy  out  1  high from start acceptance until done.
- done  out  1  single-cycle pulse after the last write.
- sat_count  out  ADDR_W  number of weights clamped in the current or last pass.
- checksum  out  SUM_W  modulo-2^SUM_W sum of all mem_din values written in the current or last pass.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - w_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, sat_count=0, checksum=0.
  - Reset mid-pass aborts immediately. No write is issued on the cycle after reset. Partial RAM contents are left as written.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - w_ready=0; w_valid is ignored.
  - start=1 -> RUN. Same edge: busy<=1, counter<=0, sat_count<=0, checksum<=0.
- RUN:
  - w_ready=1.
  - A transfer occurs on a clk edge with w_valid=1 and w_ready=1.
  - Each transfer registers, on the same edge:
    - mem_we<=1, mem_addr<=counter, mem_din<=pack(w_data).
    - counter<=counter+1; checksum and sat_count are updated.
  - Write latency is exactly 1 cycle from transfer to mem_we high.
  - Edges with no transfer set mem_we<=0.
  - The transfer with counter==NUM_WEIGHTS-1 -> FLUSH, and w_ready drops the next cycle.
  - The counter wraps to 0 after NUM_WEIGHTS-1.
- FLUSH:
  - The last write (address NUM_WEIGHTS-1) is on the port this cycle; w_ready=0.
  - Next edge: mem_we<=0, done<=1, busy<=0 -> DONE.
- DONE:
  - done is high for this one cycle.
  - Next edge: done<=0 -> IDLE.
  - sat_count and checksum hold until the next start.
- start while busy (RUN, FLUSH or DONE) is ignored.
- start arriving together with w_valid in IDLE: the start is taken; the data is not.
- pack(w), combinational:
  - mem_din[11] = w[15].
  - If w[14:11]==0: mem_din[10:0] = w[10:0].
  - Otherwise: mem_din[10:0] = 11'h7FF (saturate) and sat_count increments.
  - This is the exact inverse of the read-side unpack {w[11],4'b0,w[10:0]} for in-range values.
- sat_count saturates at its maximum value and never wraps.
- checksum adds the zero-extended 12-bit mem_din of every write.

Decomposition:
- Shared package nn_pkg holds:
  - constants NUM_WEIGHTS=784, WEIGHT_ADDR_W=10, WEIGHT_IN_W=16, WEIGHT_OUT_W=12.
  - the FSM state enum {IDLE, RUN, FLUSH, DONE}.
- Sub-module weight_pack: a purely combinational packer with ports in[15:0] -> out[11:0] and sat.
  - It is reused by any future snapshot or dump path.
- The FSM, counter and accumulators stay in weight_writer.

Test Plan:
- Full pass, no stall: rst low 2 cycles, start, w_valid held 1, w_data=i mod 2048 for i=0..783 -> 784 writes.
  - Writes to addresses 0..783 consecutively, mem_din=i mod 2048.
  - mem_we first high 1 cycle after the first transfer.
  - done pulses exactly once, 2 cycles after the last transfer; sat_count=0.
  - checksum = sum of (i mod 2048) for i=0..783 = 306936.
- Backpressure/gaps: w_valid toggles 1,0,0,1 pattern.
  - mem_we low in gap cycles.
  - Addresses remain gap-free, 0..783; no duplicate writes.
  - busy stays high throughout.
- Packing and saturation: inputs 16'h8123, 16'h0FFF, 16'h1001, 16'hF800 at addresses 0..3.
  - mem_din = 12'h923, 12'h7FF, 12'h7FF, 12'hFFF.
  - sat_count=3 at done.
- Spurious control: start pulsed during RUN at address 100, and w_valid=1 in IDLE.
  - Counter unaffected; no writes issued from IDLE.
  - w_ready=0 in IDLE; still 784 writes and one done.
- Reset mid-operation: rst=0 after the write to address 400.
  - Next cycle mem_we=0, busy=0, sat_count=0, checksum=0.
  - A following start restarts at address 0.
- Back-to-back passes: start asserted on the cycle done is high is ignored; start in IDLE the next cycle is taken.
  - The second pass begins at address 0; checksum and sat_count are cleared at the second start.
